// File: rtl/fetch_ctrl_if.sv
// Control bundle between fetch_ctrl and its neighbours: harness start/done,
// decode/branch requests in, fetch-stage controls and status out.
interface fetch_ctrl_if #(
    parameter int CW = 16
);
    logic          Start;
    logic          HaltReq;
    logic          Stall;
    logic          BrTaken;
    logic [7:0]    BrDest;
    logic          StepEn;
    logic          StepPulse;
    logic          Init;
    logic          Halt;
    logic          Branch;
    logic [7:0]    Target;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] FetchCount;

    modport master (
        output Start, HaltReq, Stall, BrTaken, BrDest, StepEn, StepPulse,
        input  Init, Halt, Branch, Target, Busy, Done, FetchCount
    );

    modport slave (
        input  Start, HaltReq, Stall, BrTaken, BrDest, StepEn, StepPulse,
        output Init, Halt, Branch, Target, Busy, Done, FetchCount
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: start/init/run/drain/done lifecycle, merging stalls,
// single-step and taken branches (with one pending-branch slot) into PC controls.
module fetch_ctrl #(
    parameter int INIT_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CW           = 16
) (
    input  logic         CLK,
    input  logic         RST_n,
    fetch_ctrl_if.slave  bus
);
    localparam int MAXC = (INIT_CYCLES > DRAIN_CYCLES) ? INIT_CYCLES : DRAIN_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;

    state_t        state, nstate;
    logic          start_q;
    logic [TW-1:0] tmr;
    logic [CW-1:0] fcnt;
    logic          pend_v, pend_v_nxt, pend_set;
    logic [7:0]    pend_dest, last_tgt;
    logic          hold, inc;
    logic          init_o, halt_o, br_o;
    logic [7:0]    tgt_o;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate     = state;
        init_o     = 1'b0;
        halt_o     = 1'b1;
        br_o       = 1'b0;
        tgt_o      = last_tgt;
        inc        = 1'b0;
        pend_set   = 1'b0;
        pend_v_nxt = pend_v;
        hold       = bus.Stall | (bus.StepEn & ~bus.StepPulse);
        case (state)
            IDLE: if (bus.Start && !start_q) nstate = INIT;
            INIT: begin
                init_o = 1'b1;
                halt_o = 1'b0;
                if (tmr == '0) nstate = RUN;
            end
            RUN: begin
                halt_o = hold;
                if (bus.HaltReq) begin
                    halt_o     = 1'b1;
                    pend_v_nxt = 1'b0;
                    nstate     = DRAIN;
                end else begin
                    inc = ~hold;
                    if (!hold && pend_v) begin
                        br_o  = 1'b1;
                        tgt_o = pend_dest;
                    end else if (!hold && bus.BrTaken) begin
                        br_o  = 1'b1;
                        tgt_o = bus.BrDest;
                    end
                    // A new branch that cannot issue now takes the pending slot,
                    // replacing an older pending one or refilling a just-issued one.
                    if (bus.BrTaken && (hold || pend_v)) begin
                        pend_set   = 1'b1;
                        pend_v_nxt = 1'b1;
                    end else if (!hold) begin
                        pend_v_nxt = 1'b0;
                    end
                end
            end
            DRAIN: if (tmr == '0) nstate = DONE;
            DONE:  if (!bus.Start) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            start_q   <= 1'b0;
            tmr       <= '0;
            fcnt      <= '0;
            pend_v    <= 1'b0;
            pend_dest <= '0;
            last_tgt  <= '0;
        end else begin
            start_q <= bus.Start;
            if (nstate != state && nstate == INIT)       tmr <= TW'(INIT_CYCLES - 1);
            else if (nstate != state && nstate == DRAIN) tmr <= TW'(DRAIN_CYCLES - 1);
            else if (tmr != '0)                          tmr <= tmr - 1'b1;
            if (state == INIT) begin
                fcnt   <= '0;
                pend_v <= 1'b0;
            end else if (state == RUN) begin
                if (inc) fcnt <= fcnt + 1'b1;
                pend_v <= pend_v_nxt;
                if (pend_set) pend_dest <= bus.BrDest;
                if (br_o)     last_tgt  <= tgt_o;
            end
        end
    end

    assign bus.Init       = init_o;
    assign bus.Halt       = halt_o;
    assign bus.Branch     = br_o;
    assign bus.Target     = tgt_o;
    assign bus.Busy       = (state != IDLE) && (state != DONE);
    assign bus.Done       = (state == DONE);
    assign bus.FetchCount = fcnt;
endmodule
